sync_deglitch_cnt: RTL and testbench



---
 rtl/sync_deglitch_pkg.sv | 20 ++
 rtl/sync_deglitch_cnt_sync_ff_chain.sv | 17 +
 rtl/sync_deglitch_cnt.sv | 96 +++++++++
 tb/tb_sync_deglitch_cnt.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_deglitch_pkg.sv
// sync_deglitch_pkg: shared FSM encoding, legal parameter bounds and sizing helpers
// for sync_deglitch_cnt and its synchroniser.
package sync_deglitch_pkg;
  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int STAB_MIN = 1;
  localparam int STAB_MAX = 255;
  function automatic int stab_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction
endpackage

// File: rtl/sync_deglitch_cnt_sync_ff_chain.sv
// sync_ff_chain: plain multi-flop synchroniser, no logic between stages,
// asynchronous active-low reset to 0.
module sync_ff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] r_chain;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_chain <= '0;
    else          r_chain <= {r_chain[SYNC_STAGES-2:0], d};
  end
  assign q = r_chain[SYNC_STAGES-1];
endmodule

// File: rtl/sync_deglitch_cnt.sv
// sync_deglitch_cnt: synchronise a glitchy net, accept a level only after it is stable,
// emit rise/fall pulses; SYNC_DEGLITCH_EDGE_CNT_EN adds a saturating edge counter.
module sync_deglitch_cnt
  import sync_deglitch_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
  ,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] edge_cnt
`endif
);
  localparam int SYNC_N = clamp(SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  localparam int STAB_N = clamp(STABLE_CYCLES, STAB_MIN, STAB_MAX);
  localparam int SW     = stab_w(STAB_N);
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);
  localparam logic [SW-1:0] CNT_LAST = SW'(STAB_N - 1);

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_cnt, w_cnt_nxt;
  logic          w_sync;
  logic          r_rise, r_fall;

  sync_ff_chain #(.SYNC_STAGES(SYNC_N)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (din),
    .q       (w_sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_LO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= ~r_state[1] & w_state_nxt[1];
      r_fall  <= r_state[1] & ~w_state_nxt[1];
    end
  end

  // r_cnt holds how many consecutive samples of the candidate level have been seen
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LO: if (w_sync) begin
        w_state_nxt = (STAB_N == 1) ? S_HI : S_CHK_HI;
        w_cnt_nxt   = (STAB_N == 1) ? '0 : CNT_ONE;
      end
      S_CHK_HI: begin
        w_state_nxt = !w_sync ? S_LO : (r_cnt == CNT_LAST) ? S_HI : S_CHK_HI;
        w_cnt_nxt   = (!w_sync || r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
      end
      S_HI: if (!w_sync) begin
        w_state_nxt = (STAB_N == 1) ? S_LO : S_CHK_LO;
        w_cnt_nxt   = (STAB_N == 1) ? '0 : CNT_ONE;
      end
      S_CHK_LO: begin
        w_state_nxt = w_sync ? S_HI : (r_cnt == CNT_LAST) ? S_LO : S_CHK_LO;
        w_cnt_nxt   = (w_sync || r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
      end
    endcase
  end

  assign dout       = r_state[1];
  assign busy       = r_state[0];
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
  logic [CNT_W-1:0] r_edge_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 r_edge_cnt <= '0;
    else if (clr_cnt)                             r_edge_cnt <= '0;
    else if ((r_rise | r_fall) && ~&r_edge_cnt)   r_edge_cnt <= r_edge_cnt + CNT_W'(1);
  end
  assign edge_cnt = r_edge_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif
endmodule

// File: tb/tb_sync_deglitch_cnt.sv
// tb_sync_deglitch_cnt: table-driven, hand-written and random checks of sync_deglitch_cnt
// against a run-length reference model; edge counter checked when SYNC_DEGLITCH_EDGE_CNT_EN is set.
module tb_sync_deglitch_cnt;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int CW   = 2;

  logic clk, reset_n, din;
  logic dout, rise_pulse, fall_pulse, busy;
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
  logic          clr_cnt;
  logic [CW-1:0] edge_cnt;
`endif

  sync_deglitch_cnt #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
    ,
    .clr_cnt    (clr_cnt),
    .edge_cnt   (edge_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: level flips once the synchronised input has differed from it for STAB samples in a row.
  bit hist [SYNC];
  bit m_lvl, m_rise, m_fall, s;
  int m_k, m_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      m_lvl = 0; m_rise = 0; m_fall = 0; m_k = 0; m_cnt = 0;
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = din;
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
      if (clr_cnt) m_cnt = 0;
      else if ((m_rise || m_fall) && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
      m_rise = 0;
      m_fall = 0;
      if (s != m_lvl) begin
        m_k++;
        if (m_k == STAB) begin
          m_lvl = s; m_k = 0; m_rise = s; m_fall = !s;
        end
      end else m_k = 0;
    end
  end

  int  cyc = 0;
  int  last_e = 0;
  bit  last_ok = 0;
  always @(posedge clk) cyc++;
  always @(negedge reset_n) last_ok = 0;

  always @(negedge clk) begin
    chk("mon_dout", dout, m_lvl);
    chk("mon_rise", rise_pulse, m_rise);
    chk("mon_fall", fall_pulse, m_fall);
    chk("mon_busy", busy, m_k != 0);
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
    chk("mon_edge_cnt", edge_cnt, m_cnt);
`endif
    chk("mon_overlap", rise_pulse & fall_pulse, 0);
    if (rise_pulse || fall_pulse) begin
      if (last_ok) chk("mon_edge_gap", (cyc - last_e) >= STAB, 1);
      last_e  = cyc;
      last_ok = 1;
    end
  end

  typedef struct {
    bit din;
    int n;
    bit dout;
    int rises;
    int falls;
    int busy;
  } vec_t;
  vec_t tbl [9];

  bit [3:0] g;
  task automatic tog(input int idx, input int per, input longint t_end);
    while ($time + per < t_end) begin
      #(per);
      if ($time % 10 == 5) #1;
      g[idx] = ~g[idx];
      din    = ^g;
    end
  endtask

  int  r, f, b;
  bit  seen;
  longint t_end;

  initial begin
    tbl = '{
      '{1'b0, 20, 1'b0, 0, 1, 3},
      '{1'b1,  3, 1'b0, 0, 0, 1},
      '{1'b0, 10, 1'b0, 0, 0, 2},
      '{1'b1, 20, 1'b1, 1, 0, 3},
      '{1'b0,  3, 1'b1, 0, 0, 1},
      '{1'b1, 20, 1'b1, 0, 0, 2},
      '{1'b0, 20, 1'b0, 0, 1, 3},
      '{1'b1,  4, 1'b0, 0, 0, 2},
      '{1'b0, 20, 1'b0, 1, 1, 4}
    };
    reset_n = 1'b0;
    din     = 1'b1;
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
    clr_cnt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_busy", busy, 0);
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
    chk("rst_edge_cnt", edge_cnt, 0);
`endif
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); @(negedge clk);
      chk("s1_dout", dout, k == 6);
      chk("s1_rise", rise_pulse, k == 6);
    end
    @(posedge clk); @(negedge clk);
    chk("s1_rise_end", rise_pulse, 0);
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
    chk("s1_edge_cnt", edge_cnt, 1);
`endif

    foreach (tbl[i]) begin
      din = tbl[i].din;
      r = 0; f = 0; b = 0;
      repeat (tbl[i].n) begin
        @(posedge clk); @(negedge clk);
        r += int'(rise_pulse); f += int'(fall_pulse); b += int'(busy);
      end
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("tbl%0d_rises", i), r, tbl[i].rises);
      chk($sformatf("tbl%0d_falls", i), f, tbl[i].falls);
      chk($sformatf("tbl%0d_busy", i), b, tbl[i].busy);
    end

`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
    chk("s5_saturated", edge_cnt, 3);
    din  = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      seen = rise_pulse;
    end
    chk("s5_rise_seen", seen, 1);
    clr_cnt = 1'b1;
    @(posedge clk); @(negedge clk);
    clr_cnt = 1'b0;
    chk("s5_clr", edge_cnt, 0);
    din = 1'b0;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    chk("s5_after_clr", edge_cnt, 1);
`endif

    din = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("s4_busy_before", busy, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("s4_busy_rst", busy, 0);
    chk("s4_dout_rst", dout, 0);
    din = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    r = 0;
    repeat (12) begin @(posedge clk); @(negedge clk); r += int'(rise_pulse); end
    chk("s4_no_rise", r, 0);
    chk("s4_dout", dout, 0);

    repeat (400) begin
      din = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) begin
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
        clr_cnt = ($urandom_range(0, 39) == 0);
`endif
        @(posedge clk); @(negedge clk);
      end
    end
`ifdef SYNC_DEGLITCH_EDGE_CNT_EN
    clr_cnt = 1'b0;
`endif

    g     = '0;
    din   = 1'b0;
    repeat (10) @(negedge clk);
    t_end = $time + 3000;
    fork
      tog(0, 37, t_end);
      tog(1, 67, t_end);
      tog(2, 157, t_end);
      tog(3, 317, t_end);
    join
    @(negedge clk);
    din = 1'b0;
    repeat (20) @(negedge clk);
    chk("s6_dout_final", dout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
